fec_decoder: RTL and testbench

// - Hamming(16,11) SECDED decoder: the inverse of the FEC encoder path.
// - On start, reads NUM_WORDS encoded 16-bit words from data memory (lo byte at SRC_BASE+2i, hi at +2i+1).
// - Corrects single-bit errors, detects double-bit errors, and writes the 11-bit data plus 2 flag bits to DST_BASE+2i / +2i+1.
// - Sits beside the encoder on the same data-memory port; top level arbitrates by start/done.

---
 rtl/fec_pkg.sv | 52 +++++
 rtl/hamming16_dec.sv | 37 +++
 rtl/fec_decoder.sv | 143 ++++++++++++++
 tb/tb_fec_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fec_pkg
// Brief   : Shared types and constants for the Hamming(16,11) SECDED path:
//           FSM state encoding, decode flags, codeword bit positions and
//           syndrome masks used by both encoder and decoder.
// Revision: 1.0 - initial release
// ============================================================================
package fec_pkg;

  // Decoder run sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_CAPT  = 3'd3,
    S_WR_LO = 3'd4,
    S_WR_HI = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  // Per-word decode outcome, stored in the top two bits of the hi byte.
  localparam logic [1:0] FLG_OK  = 2'b00;
  localparam logic [1:0] FLG_COR = 2'b01;
  localparam logic [1:0] FLG_DBL = 2'b10;

  // Parity bit positions inside the 16-bit codeword.
  localparam int POS_P0 = 0;
  localparam int POS_P1 = 1;
  localparam int POS_P2 = 2;
  localparam int POS_P4 = 4;
  localparam int POS_P8 = 8;

  // Syndrome bit k covers every position whose index has bit k set.
  localparam logic [15:0] SYN_MASK0 = 16'hAAAA;
  localparam logic [15:0] SYN_MASK1 = 16'hCCCC;
  localparam logic [15:0] SYN_MASK2 = 16'hF0F0;
  localparam logic [15:0] SYN_MASK3 = 16'hFF00;

  // Gather the 11 data bits: d0 at 3, d1..d3 at 5..7, d4..d10 at 9..15.
  function automatic logic [10:0] extract_data(input logic [15:0] cw);
    return {cw[15:9], cw[7:5], cw[3]};
  endfunction

  // 4-bit syndrome over positions 1..15; bit 0 never contributes.
  function automatic logic [3:0] syndrome(input logic [15:0] cw);
    return {^(cw & SYN_MASK3), ^(cw & SYN_MASK2),
            ^(cw & SYN_MASK1), ^(cw & SYN_MASK0)};
  endfunction

endpackage : fec_pkg
`default_nettype wire

// File: rtl/hamming16_dec.sv
`default_nettype none
// ============================================================================
// Module  : hamming16_dec
// Brief   : Combinational Hamming(16,11) SECDED decode of one codeword.
//           Single errors are corrected, double errors only flagged.
// Revision: 1.0 - initial release
// ============================================================================
module hamming16_dec
  import fec_pkg::*;
(
  input  logic [15:0] codeword_i,
  output logic [10:0] data_o,
  output logic [1:0]  flag_o
);

  logic [3:0]  syn;
  logic        par;
  logic [15:0] fixed;

  // Classify the word and, for an odd overall parity, flip the bit the
  // syndrome points at (syndrome 0 means the overall parity bit itself).
  always_comb begin
    syn    = syndrome(codeword_i);
    par    = ^codeword_i;
    fixed  = codeword_i;
    flag_o = FLG_OK;
    if (par) begin
      fixed  = codeword_i ^ (16'h0001 << syn);
      flag_o = FLG_COR;
    end else if (syn != 4'd0) begin
      flag_o = FLG_DBL;
    end
    data_o = extract_data(fixed);
  end

endmodule : hamming16_dec
`default_nettype wire

// File: rtl/fec_decoder.sv
`default_nettype none
// ============================================================================
// Module  : fec_decoder
// Brief   : Reads NUM_WORDS encoded words from data memory, SECDED-decodes
//           each one and writes data plus a 2-bit flag back, counting
//           corrected and double-error words per run.
// Revision: 1.0 - initial release
// ============================================================================
module fec_decoder
  import fec_pkg::*;
#(
  parameter int NUM_WORDS = 15,
  parameter int SRC_BASE  = 30,
  parameter int DST_BASE  = 0,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wr_data,
  output logic [3:0]        corr_cnt,
  output logic [3:0]        dbl_cnt
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        hi_q, hi_d;
  logic [3:0]        corr_q, corr_d;
  logic [3:0]        dbl_q, dbl_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [10:0]       dec_data;
  logic [1:0]        dec_flag;

  assign src_addr = ADDR_W'(SRC_BASE) + ADDR_W'({idx_q, 1'b0});
  assign dst_addr = ADDR_W'(DST_BASE) + ADDR_W'({idx_q, 1'b0});

  hamming16_dec u_dec (
    .codeword_i ({hi_q, lo_q}),
    .data_o     (dec_data),
    .flag_o     (dec_flag)
  );

  // State and datapath registers; reset returns everything to idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      corr_q  <= '0;
      dbl_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      corr_q  <= corr_d;
      dbl_q   <= dbl_d;
      done_q  <= done_d;
    end
  end

  // Next-state, memory port and counter logic; read data arrives one
  // state after its address, so lo/hi are captured a state late.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    corr_d      = corr_q;
    dbl_d       = dbl_q;
    done_d      = done_q;
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          corr_d  = '0;
          dbl_d   = '0;
          idx_d   = '0;
          state_d = S_RD_LO;
        end
      end
      S_RD_LO: begin
        mem_addr = src_addr;
        state_d  = S_RD_HI;
      end
      S_RD_HI: begin
        mem_addr = src_addr + ADDR_W'(1);
        lo_d     = mem_rd_data;
        state_d  = S_CAPT;
      end
      S_CAPT: begin
        hi_d    = mem_rd_data;
        state_d = S_WR_LO;
      end
      S_WR_LO: begin
        mem_wr_en   = 1'b1;
        mem_addr    = dst_addr;
        mem_wr_data = dec_data[7:0];
        if (dec_flag == FLG_COR && corr_q != 4'hF) corr_d = corr_q + 4'd1;
        if (dec_flag == FLG_DBL && dbl_q  != 4'hF) dbl_d  = dbl_q  + 4'd1;
        state_d = S_WR_HI;
      end
      S_WR_HI: begin
        mem_wr_en   = 1'b1;
        mem_addr    = dst_addr + ADDR_W'(1);
        mem_wr_data = {dec_flag, 3'b000, dec_data[10:8]};
        if (idx_q == LAST_IDX) begin
          state_d = S_FIN;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_RD_LO;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign done     = done_q;
  assign corr_cnt = corr_q;
  assign dbl_cnt  = dbl_q;

endmodule : fec_decoder
`default_nettype wire

// File: tb/tb_fec_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_fec_decoder
// Brief   : Directed self-checking bench for fec_decoder with a synchronous
//           byte-wide memory model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fec_decoder;

  localparam int NW  = 15;
  localparam int SRC = 30;
  localparam int DST = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data = 8'h00;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [3:0] corr_cnt;
  logic [3:0] dbl_cnt;

  logic [7:0] mem [0:255];
  logic       tb_we = 1'b0;
  logic [7:0] tb_waddr = 8'h00;
  logic [7:0] tb_wdata = 8'h00;
  int         wr_count = 0;

  int n_checks = 0;
  int n_pass   = 0;

  fec_decoder #(.NUM_WORDS(NW), .SRC_BASE(SRC), .DST_BASE(DST), .ADDR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .done        (done),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .corr_cnt    (corr_cnt),
    .dbl_cnt     (dbl_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory with a bench preload port.
  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count      <= wr_count + 1;
    end
    if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  // Reference encoder built from the codeword layout definition.
  function automatic logic [15:0] enc(input logic [10:0] d);
    logic [15:0] cw;
    cw        = 16'h0000;
    cw[3]     = d[0];
    cw[7:5]   = d[3:1];
    cw[15:9]  = d[10:4];
    cw[1]     = ^(cw & 16'hAAAA);
    cw[2]     = ^(cw & 16'hCCCC);
    cw[4]     = ^(cw & 16'hF0F0);
    cw[8]     = ^(cw & 16'hFF00);
    cw[0]     = ^cw;
    return cw;
  endfunction

  task automatic poke(input int a, input logic [7:0] d);
    @(negedge clk);
    tb_we    = 1'b1;
    tb_waddr = 8'(a);
    tb_wdata = d;
    @(posedge clk);
    #1 tb_we = 1'b0;
  endtask

  // All source words clean (EE,D2), destination pre-filled with 55.
  task automatic prep_clean;
    for (int i = 0; i < NW; i++) begin
      poke(SRC + 2*i, 8'hEE);
      poke(SRC + 2*i + 1, 8'hD2);
    end
    for (int i = 0; i < 2*NW; i++) poke(DST + i, 8'h55);
  endtask

  task automatic start_run;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < 300) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  // Returns the first destination word index (from first_w) not equal to
  // 9F/06, or -1 when all match.
  function automatic int first_bad_clean(input int first_w);
    for (int i = first_w; i < NW; i++)
      if (mem[DST+2*i] !== 8'h9F || mem[DST+2*i+1] !== 8'h06) return i;
    return -1;
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_checks++; if (mem_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); else n_pass++;
    n_checks++; if (mem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", mem_addr); else n_pass++;
    n_checks++; if (mem_wr_data !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", mem_wr_data); else n_pass++;
    n_checks++; if (corr_cnt !== 4'd0) $display("FAIL reset_corr: got %0d want 0", corr_cnt); else n_pass++;
    n_checks++; if (dbl_cnt !== 4'd0) $display("FAIL reset_dbl: got %0d want 0", dbl_cnt); else n_pass++;
    // start together with reset must not begin a run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++; if (wr_count !== 0) $display("FAIL reset_wins: got %0d writes want 0", wr_count); else n_pass++;
  endtask

  task automatic test_clean;
    int cyc;
    int bad;
    prep_clean();
    start_run();
    n_checks++; if (done !== 1'b0) $display("FAIL clean_done_low: got %b want 0", done); else n_pass++;
    wait_done(cyc);
    n_checks++; if (cyc !== 76) $display("FAIL clean_latency: got %0d cycles want 76", cyc); else n_pass++;
    n_checks++; if (mem[0] !== 8'h9F) $display("FAIL clean_lo: got %h want 9F", mem[0]); else n_pass++;
    n_checks++; if (mem[1] !== 8'h06) $display("FAIL clean_hi: got %h want 06", mem[1]); else n_pass++;
    bad = first_bad_clean(0);
    n_checks++; if (bad !== -1) $display("FAIL clean_all: bad word %0d want none", bad); else n_pass++;
    n_checks++; if (corr_cnt !== 4'd0) $display("FAIL clean_corr: got %0d want 0", corr_cnt); else n_pass++;
    n_checks++; if (dbl_cnt !== 4'd0) $display("FAIL clean_dbl: got %0d want 0", dbl_cnt); else n_pass++;
  endtask

  // One faulty word 0 among clean words; checks outputs and counters.
  task automatic test_word0(input string nm, input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                            input logic [3:0] exp_corr, input logic [3:0] exp_dbl);
    int cyc;
    int bad;
    prep_clean();
    poke(SRC, lo);
    poke(SRC + 1, hi);
    start_run();
    wait_done(cyc);
    n_checks++; if (cyc !== 76) $display("FAIL %s_latency: got %0d want 76", nm, cyc); else n_pass++;
    n_checks++; if (mem[0] !== exp_lo) $display("FAIL %s_lo: got %h want %h", nm, mem[0], exp_lo); else n_pass++;
    n_checks++; if (mem[1] !== exp_hi) $display("FAIL %s_hi: got %h want %h", nm, mem[1], exp_hi); else n_pass++;
    bad = first_bad_clean(1);
    n_checks++; if (bad !== -1) $display("FAIL %s_rest: bad word %0d want none", nm, bad); else n_pass++;
    repeat (5) @(negedge clk);
    n_checks++; if (corr_cnt !== exp_corr) $display("FAIL %s_corr: got %0d want %0d", nm, corr_cnt, exp_corr); else n_pass++;
    n_checks++; if (dbl_cnt !== exp_dbl) $display("FAIL %s_dbl: got %0d want %0d", nm, dbl_cnt, exp_dbl); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL %s_done_hold: got %b want 1", nm, done); else n_pass++;
  endtask

  task automatic test_full_run;
    logic [10:0] d [NW];
    logic [15:0] cw;
    int cyc;
    int bad;
    for (int i = 0; i < NW; i++) begin
      d[i] = 11'((i * 379 + 91) & 16'h07FF);
      cw   = enc(d[i]) ^ (16'h0001 << $urandom_range(0, 15));
      poke(SRC + 2*i, cw[7:0]);
      poke(SRC + 2*i + 1, cw[15:8]);
    end
    start_run();
    wait_done(cyc);
    n_checks++; if (cyc !== 76) $display("FAIL full_latency: got %0d want 76", cyc); else n_pass++;
    bad = -1;
    for (int i = 0; i < NW; i++)
      if (bad < 0 && (mem[DST+2*i] !== d[i][7:0] ||
                      mem[DST+2*i+1] !== {2'b01, 3'b000, d[i][10:8]})) bad = i;
    n_checks++;
    if (bad !== -1)
      $display("FAIL full_bytes: word %0d got %h%h want %h%h", bad, mem[DST+2*bad+1], mem[DST+2*bad],
               {2'b01, 3'b000, d[bad][10:8]}, d[bad][7:0]);
    else n_pass++;
    n_checks++; if (corr_cnt !== 4'd15) $display("FAIL full_corr: got %0d want 15", corr_cnt); else n_pass++;
    n_checks++; if (dbl_cnt !== 4'd0) $display("FAIL full_dbl: got %0d want 0", dbl_cnt); else n_pass++;
  endtask

  task automatic test_midrun_start;
    int cyc;
    prep_clean();
    start_run();
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      if (cyc == 10) start = 1'b1;
      if (cyc == 11) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    n_checks++; if (cyc !== 76) $display("FAIL midstart_latency: got %0d want 76", cyc); else n_pass++;
  endtask

  task automatic test_reset_midrun;
    int cyc;
    int wc;
    int bad;
    prep_clean();
    start_run();
    repeat (20) @(negedge clk);
    reset = 1'b1;
    wc = wr_count;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++; if (wr_count !== wc) $display("FAIL rstmid_writes: got %0d extra want 0", wr_count - wc); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rstmid_done: got %b want 0", done); else n_pass++;
    n_checks++; if (mem[6] !== 8'h9F || mem[7] !== 8'h06)
      $display("FAIL rstmid_kept: got %h %h want 9F 06", mem[6], mem[7]); else n_pass++;
    n_checks++; if (mem[8] !== 8'h55) $display("FAIL rstmid_untouched: got %h want 55", mem[8]); else n_pass++;
    start_run();
    wait_done(cyc);
    n_checks++; if (cyc !== 76) $display("FAIL restart_latency: got %0d want 76", cyc); else n_pass++;
    bad = first_bad_clean(0);
    n_checks++; if (bad !== -1) $display("FAIL restart_all: bad word %0d want none", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_word0("single_b5", 8'hCE, 8'hD2, 8'h9F, 8'h46, 4'd1, 4'd0);
    test_word0("p0",        8'hEF, 8'hD2, 8'h9F, 8'h46, 4'd1, 4'd0);
    test_word0("double",    8'hE6, 8'hD6, 8'hBE, 8'h86, 4'd0, 4'd1);
    test_full_run();
    test_midrun_start();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fec_decoder
`default_nettype wire
